cla_add_4b: RTL and testbench
=============================

CLA_ADD_4B -- requirements
Module: cla_add_4b

Interface
REQ-001 SHALL have parameter REG_OUT, default 1; 1 = registered outputs (latency 1), 0 = combinational outputs with clk/rst_n affecting only out_valid.
REQ-002 SHALL have port clk, input, 1 bit: single clock, all state on rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have port in_valid, input, 1 bit: operands valid this cycle.
REQ-005 SHALL have port in_a, input, 4 bits: operand A, unsigned (also read as two's complement for ovf).
REQ-006 SHALL have port in_b, input, 4 bits: operand B.
REQ-007 SHALL have port c_i, input, 1 bit: carry-in.
REQ-008 SHALL have port out, output, 4 bits: sum bits [3:0].
REQ-009 SHALL have port c_o, output, 1 bit: carry-out (sum bit 4).
REQ-010 SHALL have port g_o, output, 1 bit: group generate.
REQ-011 SHALL have port p_o, output, 1 bit: group propagate.
REQ-012 SHALL have port ovf, output, 1 bit: signed two's-complement overflow.
REQ-013 SHALL have port out_valid, output, 1 bit: outputs hold a result.

Function
REQ-014 Per bit i, g_i = in_a[i] AND in_b[i] and p_i = in_a[i] XOR in_b[i].
REQ-015 Carries SHALL be lookahead, not rippled: c0 = c_i; c(i+1) = g_i OR (p_i AND c_i) expanded into flat two-level sum-of-products of g, p and c_i.
REQ-016 out[i] = p_i XOR c_i for each bit i.
REQ-017 g_o = g3 | p3g2 | p3p2g1 | p3p2p1g0, and p_o = p3p2p1p0.
REQ-018 c_o = g_o | (p_o & c_i), so {c_o,out} SHALL equal in_a + in_b + c_i exactly (range 0..31).
REQ-019 ovf = c4 XOR c3, i.e. asserted when in_a[3] == in_b[3] and out[3] differs.
REQ-020 With REG_OUT=1, a cycle with in_valid=1 SHALL update out, c_o, g_o, p_o and ovf on the next rising edge and set out_valid=1 (latency exactly 1 cycle).
REQ-021 With REG_OUT=1, a cycle with in_valid=0 SHALL hold the result registers and clear out_valid on the next edge.
REQ-022 Back-to-back in_valid=1 cycles SHALL produce one result per cycle with no bubbles or stalls.
REQ-023 With REG_OUT=0, the result outputs SHALL be purely combinational from the current inputs, and out_valid SHALL be in_valid registered one cycle.
REQ-024 No X propagation: all outputs SHALL be defined from the first edge after reset.

Reset
REQ-025 While rst_n=0 at a rising edge, out=0, c_o=0, g_o=0, p_o=0, ovf=0 and out_valid=0 on the following cycle.
REQ-026 Reset SHALL override in_valid on the same edge; any result in flight SHALL be discarded.
REQ-027 After rst_n rises, the first in_valid=1 cycle SHALL produce its result one edge later, as in normal operation.

Structure
REQ-028 The width constant (4) and the result-bundle field widths SHALL live in the shared package cla_pkg.
REQ-029 The combinational lookahead logic (REQ-014 to REQ-019) SHALL be one sub-module, cla_core_4b, instantiated once; cla_add_4b adds only registers and valid handling.
REQ-030 Must not use the "+" operator for the sum; it must be explicitly gate-level lookahead.

Verification
REQ-031 Reset: rst_n=0 for 2 cycles with in_valid=1, in_a=15, in_b=15 -> all outputs 0 and out_valid=0.
REQ-032 Wrap: in_a=15, in_b=1, c_i=0, in_valid=1 -> next cycle out=0, c_o=1, p_o=0, g_o=1, ovf=0, out_valid=1.
REQ-033 Overflow: in_a=7, in_b=1 -> out=8, c_o=0, ovf=1; and in_a=8, in_b=8 -> out=0, c_o=1, ovf=1.
REQ-034 Propagate: in_a=5, in_b=10, c_i=1 -> out=0, c_o=1, p_o=1, g_o=0; same with c_i=0 -> out=15, c_o=0.
REQ-035 Hold: result for 3+4 (out=7), then in_valid=0 for 3 cycles -> out stays 7, out_valid=0.
REQ-036 Exhaustive: all 512 (in_a, in_b, c_i) combinations streamed back-to-back -> {c_o,out} equals the arithmetic sum each cycle at latency 1, for both REG_OUT=1 and REG_OUT=0.

Source files
------------

// File: rtl/cla_pkg.sv
// Shared constants and result bundle for the 4-bit carry-lookahead adder.
package cla_pkg;

    localparam int CLA_W = 4;

    typedef struct packed {
        logic [CLA_W-1:0] sum;
        logic             c_o;
        logic             g_o;
        logic             p_o;
        logic             ovf;
    } cla_res_t;

endpackage

// File: rtl/cla_core_4b.sv
// Combinational 4-bit carry-lookahead core: per-bit generate/propagate,
// flat sum-of-products carries, group g/p and signed overflow.
module cla_core_4b
    import cla_pkg::*;
(
    input  logic [CLA_W-1:0] a,
    input  logic [CLA_W-1:0] b,
    input  logic             c_i,
    output cla_res_t         res
);

    logic [CLA_W-1:0] g;
    logic [CLA_W-1:0] p;
    logic [CLA_W:0]   c;
    logic             grp_g;
    logic             grp_p;

    // Every carry is two-level AND-OR of g, p and c_i; no carry feeds another.
    always_comb begin
        g = a & b;
        p = a ^ b;

        grp_g = g[3]
              | (p[3] & g[2])
              | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]);
        grp_p = p[3] & p[2] & p[1] & p[0];

        c[0] = c_i;
        c[1] = g[0]
             | (p[0] & c_i);
        c[2] = g[1]
             | (p[1] & g[0])
             | (p[1] & p[0] & c_i);
        c[3] = g[2]
             | (p[2] & g[1])
             | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & c_i);
        c[4] = grp_g | (grp_p & c_i);

        res.sum = p ^ c[CLA_W-1:0];
        res.c_o = c[4];
        res.g_o = grp_g;
        res.p_o = grp_p;
        res.ovf = c[4] ^ c[3];
    end

endmodule

// File: rtl/cla_add_4b.sv
// 4-bit lookahead adder wrapper: optional result register plus valid tracking.
// REG_OUT=0 leaves the result combinational; out_valid is always registered.
module cla_add_4b
    import cla_pkg::*;
#(
    parameter bit REG_OUT = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [CLA_W-1:0] in_a,
    input  logic [CLA_W-1:0] in_b,
    input  logic             c_i,
    output logic [CLA_W-1:0] out,
    output logic             c_o,
    output logic             g_o,
    output logic             p_o,
    output logic             ovf,
    output logic             out_valid
);

    cla_res_t core_res;
    cla_res_t res_out;
    logic     out_valid_d;
    logic     out_valid_q;

    cla_core_4b u_core (
        .a   (in_a),
        .b   (in_b),
        .c_i (c_i),
        .res (core_res)
    );

    always_comb begin
        out_valid_d = in_valid;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
        end
    end

    generate
        if (REG_OUT) begin : g_reg
            cla_res_t res_d;
            cla_res_t res_q;

            // Idle cycles keep the last result on the outputs.
            always_comb begin
                res_d = res_q;
                if (in_valid) begin
                    res_d = core_res;
                end
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    res_q <= '0;
                end else begin
                    res_q <= res_d;
                end
            end

            assign res_out = res_q;
        end else begin : g_comb
            assign res_out = core_res;
        end
    endgenerate

    assign out       = res_out.sum;
    assign c_o       = res_out.c_o;
    assign g_o       = res_out.g_o;
    assign p_o       = res_out.p_o;
    assign ovf       = res_out.ovf;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_cla_add_4b.sv
// Self-checking bench for cla_add_4b: registered and combinational variants
// against an arithmetic reference model, plus literal directed expectations.
module tb_cla_add_4b;

    typedef struct packed {
        logic [3:0] sum;
        logic       c_o;
        logic       g_o;
        logic       p_o;
        logic       ovf;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] in_a;
    logic [3:0] in_b;
    logic       c_i;

    logic [3:0] r_out, c_out;
    logic       r_c_o, r_g_o, r_p_o, r_ovf, r_vld;
    logic       c_c_o, c_g_o, c_p_o, c_ovf, c_vld;

    int   checks = 0;
    int   errors = 0;

    exp_t exp_q;
    logic exp_vld;
    bit   model_ok = 1'b0;

    cla_add_4b #(.REG_OUT(1'b1)) dut_reg (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_a(in_a), .in_b(in_b),
        .c_i(c_i), .out(r_out), .c_o(r_c_o), .g_o(r_g_o), .p_o(r_p_o),
        .ovf(r_ovf), .out_valid(r_vld)
    );

    cla_add_4b #(.REG_OUT(1'b0)) dut_comb (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_a(in_a), .in_b(in_b),
        .c_i(c_i), .out(c_out), .c_o(c_c_o), .g_o(c_g_o), .p_o(c_p_o),
        .ovf(c_ovf), .out_valid(c_vld)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: plain integer arithmetic, unsigned and signed views.
    function automatic exp_t ref_calc(int a, int b, int ci);
        exp_t r;
        int   t, sa, sb, ss;
        t  = a + b + ci;
        sa = (a > 7) ? a - 16 : a;
        sb = (b > 7) ? b - 16 : b;
        ss = sa + sb + ci;
        r.sum = 4'(t % 16);
        r.c_o = (t > 15);
        r.g_o = (a + b > 15);
        r.p_o = (a + b == 15);
        r.ovf = (ss > 7) || (ss < -8);
        return r;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            exp_q    <= '0;
            exp_vld  <= 1'b0;
            model_ok <= 1'b1;
        end else begin
            exp_vld <= in_valid;
            if (in_valid) begin
                exp_q <= ref_calc(int'(in_a), int'(in_b), int'(c_i));
            end
        end
    end

    task automatic chk(string name, logic [7:0] act, logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (model_ok) begin
            chk("reg_result", {3'b0, r_out, r_c_o, r_g_o, r_p_o, r_ovf}, {3'b0, exp_q});
            chk("reg_valid", {7'b0, r_vld}, {7'b0, exp_vld});
            chk("comb_result", {3'b0, c_out, c_c_o, c_g_o, c_p_o, c_ovf},
                {3'b0, ref_calc(int'(in_a), int'(in_b), int'(c_i))});
            chk("comb_valid", {7'b0, c_vld}, {7'b0, exp_vld});
        end
    end

    task automatic apply(logic v, logic [3:0] a, logic [3:0] b, logic ci);
        in_valid = v;
        in_a     = a;
        in_b     = b;
        c_i      = ci;
    endtask

    // Literal expectation on the registered variant: {out, c_o, g_o, p_o, ovf, out_valid}.
    task automatic lit(string name, logic [3:0] o, logic co, logic go, logic po,
                       logic ov, logic vld);
        chk(name, {2'b0, r_out, r_c_o, r_g_o, r_p_o, r_ovf, r_vld},
            {2'b0, o, co, go, po, ov, vld});
    endtask

    initial begin
        rst_n = 1'b0;
        apply(1'b1, 4'd15, 4'd15, 1'b0);
        repeat (2) @(posedge clk);
        #1 lit("reset", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        rst_n = 1'b1;
        apply(1'b1, 4'd15, 4'd1, 1'b0);
        @(posedge clk);
        #1 lit("wrap_15_1", 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);

        apply(1'b1, 4'd7, 4'd1, 1'b0);
        @(posedge clk);
        #1 lit("ovf_7_1", 4'd8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

        apply(1'b1, 4'd8, 4'd8, 1'b0);
        @(posedge clk);
        #1 lit("ovf_8_8", 4'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);

        apply(1'b1, 4'd5, 4'd10, 1'b1);
        @(posedge clk);
        #1 lit("prop_ci1", 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);

        apply(1'b1, 4'd5, 4'd10, 1'b0);
        @(posedge clk);
        #1 lit("prop_ci0", 4'd15, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

        apply(1'b1, 4'd3, 4'd4, 1'b0);
        @(posedge clk);
        #1 lit("hold_load", 4'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, 4'd15, 4'(i + 9), 1'b1);
            @(posedge clk);
            #1 lit("hold_idle", 4'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        // Reset mid-stream discards the in-flight result.
        apply(1'b1, 4'd9, 4'd9, 1'b1);
        rst_n = 1'b0;
        @(posedge clk);
        #1 lit("reset_flush", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        apply(1'b1, 4'd2, 4'd3, 1'b1);
        @(posedge clk);
        #1 lit("post_reset", 4'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        for (int i = 0; i < 512; i++) begin
            apply(1'b1, 4'(i >> 5), 4'((i >> 1) & 15), 1'(i & 1));
            @(posedge clk);
            #1;
        end

        for (int i = 0; i < 400; i++) begin
            rst_n = ($urandom_range(0, 31) != 0);
            apply(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            @(posedge clk);
            #1;
        end

        rst_n = 1'b1;
        apply(1'b0, 4'd0, 4'd0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
